mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external memory port between the instruction fetch path (imem) and the data path (writebuffer output, dmem).
- Captures one-cycle request pulses from each side, grants one at a time, forwards the request, and routes mem_rdata/mem_ready back to the owner.
- Sits between the core's fetch and writebuffer and the memory/bus interface.

Parameters:
- starve_limit, 4: max consecutive data grants while an imem request waits; at the limit, imem wins the next grant. Must be ≥1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- imem_in  input  mem_in_type  fetch request (mem_valid pulse, mem_instr=1)
- imem_out  output  mem_out_type  fetch response
- dmem_in  input  mem_in_type  data request from writebuffer (load/store/fence)
- dmem_out  output  mem_out_type  data response
- mem_out  input  mem_out_type  response from memory
- mem_in  output  mem_in_type  request to memory

Interface rules (already decided): one clock, clk; reset rst is asynchronous and active-low. rst==0 clears all registers immediately, independent of clk.

Behaviour:
- Registers:
  - ipend, dpend: pending flags.
  - ireq, dreq: captured mem_in_type.
  - state ∈ {IDLE, BUSY_I, BUSY_D}.
  - scnt: starvation counter, $clog2(starve_limit+1) bits.
- Capture: when x_in.mem_valid=1 and xpend=0, latch the request and set xpend. If x_in.mem_valid=1 and xpend=1 (protocol violation), ignore it and keep the first request.
- Grant decision is combinational each cycle, with the candidate set = pending flags OR same-cycle valid inputs (zero-cycle bypass).
  - Both candidates: grant D unless scnt==starve_limit, then grant I.
  - Single candidate: grant it.
- Grant cycle:
  - mem_in = granted request, with mem_valid=1 for exactly one cycle.
  - mem_instr=1 for I; for D it is forced 0 and mem_fence is passed through.
  - state → BUSY_I/BUSY_D; the granted pending flag is cleared.
- BUSY_x:
  - mem_in.mem_valid=0; other fields hold the granted request.
  - Wait for mem_out.mem_ready.
  - Ready cycle: x_out.mem_ready=1 and x_out.mem_rdata=mem_out.mem_rdata, combinationally in the same cycle. The other out is ready=0, rdata=0.
  - In that same cycle a new grant may issue (no bubble); otherwise state → IDLE.
- scnt:
  - Increments (saturating at starve_limit) on a D grant while I is a candidate.
  - Clears on an I grant, or when no I candidate exists.
- mem_ready while IDLE is ignored; both outs stay 0.
- Reset values:
  - All mem_in fields 0; imem_out and dmem_out all 0.
  - state=IDLE, pend flags 0, scnt=0.
- Reset mid-transaction: the outstanding access is abandoned and no ready is delivered. A late mem_ready after reset release, arriving in IDLE, is ignored.
- Latency: request pulse in an idle cycle → mem_in.mem_valid in the same cycle; response is passed through with 0 added cycles.

Optional Feature:
- MEM_ARBITER_ROUND_ROBIN_EN
- Defined: when both are candidates, grant alternates, with last-granted tracked by a 1-bit register (reset 0 = D granted last, so I first). scnt and starve_limit are unused.
- Undefined: data priority with starvation limit as above.

Decomposition:
- Package constants: state encoding (arb_idle/arb_busy_i/arb_busy_d).
- Package wires: reuse mem_in_type/mem_out_type; no new structs.
- The register record is a local typedef in the module, in the two-process style (comb v/rin, ff r).
- No sub-module; the grant logic is small enough to stay inline.

Test Plan:
- Idle, imem pulse addr 0x100 → same-cycle mem_in.mem_valid=1, mem_instr=1, addr 0x100. Then mem_ready with rdata 0xDEADBEEF 3 cycles later → imem_out.mem_ready=1, rdata 0xDEADBEEF in that cycle; dmem_out stays 0.
- Simultaneous imem (0x200) and dmem store (0x8000, wstrb 0xF) pulses → D granted first. I is issued in the cycle D's mem_ready arrives, with no idle cycle between.
- Data flood (starve_limit=4): imem pending, dmem pulses each completion → exactly 4 D grants, then I; scnt returns to 0.
- dmem fence pulse → mem_in.mem_fence=1, mem_valid=1 one cycle; dmem_out.mem_ready follows mem_ready.
- Second imem pulse while imem is pending → ignored; only the first address reaches memory. Reset asserted in BUSY_D → outputs 0 immediately; a stray mem_ready after release produces no ready.
- With MEM_ARBITER_ROUND_ROBIN_EN: continuous requests from both sides → grants alternate I, D, I, D starting with I.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the memory-port arbiter:
//   mem_in_type   request bundle toward memory (valid pulse, instr/fence flags,
//                 address, write data, byte strobes)
//   mem_out_type  response bundle from memory (ready pulse, read data)
//   arb_state_t   arbiter state encoding (arb_idle / arb_busy_i / arb_busy_d)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic        mem_fence;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;

   typedef enum logic [1:0] {
      arb_idle   = 2'd0,
      arb_busy_i = 2'd1,
      arb_busy_d = 2'd2
   } arb_state_t;

   localparam mem_in_type MEM_IN_ZERO = '{
      mem_valid: 1'b0,
      mem_instr: 1'b0,
      mem_fence: 1'b0,
      mem_addr:  32'h0000_0000,
      mem_wdata: 32'h0000_0000,
      mem_wstrb: 4'h0
   };

   localparam mem_out_type MEM_OUT_ZERO = '{
      mem_ready: 1'b0,
      mem_rdata: 32'h0000_0000
   };

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one external memory port between instruction fetch (imem) and the
// data path (dmem, fed by the writebuffer). One-cycle request pulses from each
// side are captured, one access is granted at a time, and the memory response
// is routed back to the owner with no added latency.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-low reset
//   imem_in   fetch request (mem_valid pulse)
//   imem_out  fetch response
//   dmem_in   data request (load/store/fence)
//   dmem_out  data response
//   mem_out   response from memory
//   mem_in    request to memory
//
// Parameter:
//   starve_limit  max consecutive data grants while a fetch waits (>= 1)
//
// Build option:
//   MEM_ARBITER_ROUND_ROBIN_EN  when defined, contention alternates between
//   the two sides instead of favouring data with a starvation limit.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int starve_limit = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   input  mem_out_type mem_out,
   output mem_in_type  mem_in
);

   localparam int SW = $clog2(starve_limit + 1);
   localparam logic [SW-1:0] SCNT_MAX = SW'(starve_limit);

   typedef struct packed {
      arb_state_t    state;
      logic          ipend;
      logic          dpend;
      mem_in_type    ireq;
      mem_in_type    dreq;
      mem_in_type    act;     // request currently owning the memory port
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      logic          last_i;  // 1: fetch was granted last
`else
      logic [SW-1:0] scnt;    // data grants issued while a fetch was waiting
`endif
   } reg_type;

   localparam reg_type REG_RESET = '{
      state: arb_idle,
      ipend: 1'b0,
      dpend: 1'b0,
      ireq:  MEM_IN_ZERO,
      dreq:  MEM_IN_ZERO,
      act:   MEM_IN_ZERO,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_i: 1'b0
`else
      scnt:  {SW{1'b0}}
`endif
   };

   reg_type    r_r;
   reg_type    rin_s;
   mem_in_type isel_s;
   mem_in_type dsel_s;
   logic       icand_s;
   logic       dcand_s;
   logic       can_gnt_s;
   logic       pick_i_s;
   logic       gnt_i_s;
   logic       gnt_d_s;

   // Next-state, arbitration and output routing.
   always_comb begin
      reg_type v;
      v        = r_r;
      imem_out = MEM_OUT_ZERO;
      dmem_out = MEM_OUT_ZERO;
      mem_in   = MEM_IN_ZERO;
      can_gnt_s = 1'b0;

      // A pending request wins over a same-cycle pulse from the same side, so
      // a second pulse while pending never reaches memory.
      if (r_r.ipend) begin
         isel_s = r_r.ireq;
      end else begin
         isel_s = imem_in;
      end
      isel_s.mem_valid = 1'b1;
      isel_s.mem_instr = 1'b1;

      if (r_r.dpend) begin
         dsel_s = r_r.dreq;
      end else begin
         dsel_s = dmem_in;
      end
      dsel_s.mem_valid = 1'b1;
      dsel_s.mem_instr = 1'b0;

      // Same-cycle pulses count as candidates so an idle port grants at once.
      icand_s = r_r.ipend | imem_in.mem_valid;
      dcand_s = r_r.dpend | dmem_in.mem_valid;

      if (imem_in.mem_valid && !r_r.ipend) begin
         v.ipend = 1'b1;
         v.ireq  = imem_in;
      end else begin
         v.ireq  = r_r.ireq;
      end

      if (dmem_in.mem_valid && !r_r.dpend) begin
         v.dpend = 1'b1;
         v.dreq  = dmem_in;
      end else begin
         v.dreq  = r_r.dreq;
      end

      // The ready cycle of a busy access also frees the port for a new grant.
      case (r_r.state)
         arb_idle: begin
            can_gnt_s = 1'b1;
         end
         arb_busy_i: begin
            mem_in           = r_r.act;
            mem_in.mem_valid = 1'b0;
            if (mem_out.mem_ready) begin
               imem_out  = mem_out;
               can_gnt_s = 1'b1;
            end else begin
               can_gnt_s = 1'b0;
            end
         end
         arb_busy_d: begin
            mem_in           = r_r.act;
            mem_in.mem_valid = 1'b0;
            if (mem_out.mem_ready) begin
               dmem_out  = mem_out;
               can_gnt_s = 1'b1;
            end else begin
               can_gnt_s = 1'b0;
            end
         end
         default: begin
            can_gnt_s = 1'b1;
         end
      endcase

      if (icand_s && dcand_s) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         pick_i_s = ~r_r.last_i;
`else
         pick_i_s = (r_r.scnt == SCNT_MAX);
`endif
      end else begin
         pick_i_s = icand_s;
      end

      // No grant may leak onto the memory port while reset is held.
      gnt_i_s = rst & can_gnt_s & icand_s & pick_i_s;
      gnt_d_s = rst & can_gnt_s & dcand_s & ~pick_i_s;

      if (gnt_i_s) begin
         mem_in  = isel_s;
         v.act   = isel_s;
         v.ipend = 1'b0;
         v.state = arb_busy_i;
      end else if (gnt_d_s) begin
         mem_in  = dsel_s;
         v.act   = dsel_s;
         v.dpend = 1'b0;
         v.state = arb_busy_d;
      end else if (can_gnt_s) begin
         v.state = arb_idle;
      end else begin
         v.state = r_r.state;
      end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (gnt_i_s) begin
         v.last_i = 1'b1;
      end else if (gnt_d_s) begin
         v.last_i = 1'b0;
      end else begin
         v.last_i = r_r.last_i;
      end
`else
      // Only data grants that bypass a waiting fetch count toward starvation.
      if (gnt_i_s || !icand_s) begin
         v.scnt = {SW{1'b0}};
      end else if (gnt_d_s && (r_r.scnt != SCNT_MAX)) begin
         v.scnt = r_r.scnt + SW'(1);
      end else begin
         v.scnt = r_r.scnt;
      end
`endif

      rin_s = v;
   end

   // State register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_r <= REG_RESET;
      end else begin
         r_r <= rin_s;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Each driven request pushes its expected
// memory-side appearance (fields and grant cycle) onto a scoreboard queue; a
// fixed-latency memory model answers every grant, and the monitor matches
// grants and responses against the scoreboard.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   mem_in_type  imem_in;
   mem_out_type imem_out;
   mem_in_type  dmem_in;
   mem_out_type dmem_out;
   mem_out_type mem_out;
   mem_in_type  mem_in;

   always #5 clk = ~clk;

   mem_arbiter #(.starve_limit(LIMIT)) dut (
      .clk      (clk),
      .rst      (rst),
      .imem_in  (imem_in),
      .imem_out (imem_out),
      .dmem_in  (dmem_in),
      .dmem_out (dmem_out),
      .mem_out  (mem_out),
      .mem_in   (mem_in)
   );

   typedef struct {
      logic [31:0] addr;
      logic        instr;
      logic        fence;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          mem_lat = 3;
   int          mcnt = 0;
   logic        out_live = 1'b0;
   logic        out_i = 1'b0;
   logic [31:0] out_addr = 32'h0;

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      else return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Called at the falling edge: compare everything the DUT shows this cycle.
   task automatic monitor();
      int idx;
      if (!rst) begin
         check_eq("rst_mem_in", 128'(mem_in), 128'(MEM_IN_ZERO));
         check_eq("rst_outs", 128'({imem_out, dmem_out}), 128'h0);
         out_live = 1'b0;
      end else begin
         if (out_live && !mem_in.mem_valid)
            check_eq("hold_addr", 128'(mem_in.mem_addr), 128'(out_addr));
         if (mem_out.mem_ready && out_live) begin
            if (out_i) begin
               check_eq("i_ready", 128'(imem_out.mem_ready), 128'h1);
               check_eq("i_rdata", 128'(imem_out.mem_rdata), 128'(rdata_of(out_addr)));
               check_eq("d_quiet", 128'(dmem_out), 128'h0);
            end else begin
               check_eq("d_ready", 128'(dmem_out.mem_ready), 128'h1);
               check_eq("d_rdata", 128'(dmem_out.mem_rdata), 128'(rdata_of(out_addr)));
               check_eq("i_quiet", 128'(imem_out), 128'h0);
            end
            out_live = 1'b0;
         end else begin
            check_eq("outs_quiet", 128'({imem_out, dmem_out}), 128'h0);
         end
         if (mem_in.mem_valid) begin
            idx = -1;
            foreach (exp_q[k]) if (idx < 0 && exp_q[k].addr == mem_in.mem_addr) idx = k;
            check_eq("req_known", 128'(idx >= 0), 128'h1);
            if (idx >= 0) begin
               check_eq("req_instr", 128'(mem_in.mem_instr), 128'(exp_q[idx].instr));
               check_eq("req_fence", 128'(mem_in.mem_fence), 128'(exp_q[idx].fence));
               check_eq("req_wdata", 128'(mem_in.mem_wdata), 128'(exp_q[idx].wdata));
               check_eq("req_wstrb", 128'(mem_in.mem_wstrb), 128'(exp_q[idx].wstrb));
               check_eq("grant_cycle", 128'(cyc), 128'(exp_q[idx].due));
               check_eq("one_outstanding", 128'(mcnt), 128'h0);
               out_live = 1'b1;
               out_i    = exp_q[idx].instr;
               out_addr = exp_q[idx].addr;
               mcnt     = mem_lat;
               exp_q.delete(idx);
            end
         end
      end
   endtask

   // Advance one cycle; on return the caller drives inputs for cycle 'cyc'.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      imem_in = MEM_IN_ZERO;
      dmem_in = MEM_IN_ZERO;
      mem_out = MEM_OUT_ZERO;
      if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            mem_out.mem_ready = 1'b1;
            mem_out.mem_rdata = rdata_of(out_addr);
         end
      end
   endtask

   task automatic req_i(input logic [31:0] addr, input logic push, input int due);
      imem_in           = MEM_IN_ZERO;
      imem_in.mem_valid = 1'b1;
      imem_in.mem_instr = 1'b1;
      imem_in.mem_addr  = addr;
      if (push) exp_q.push_back('{addr: addr, instr: 1'b1, fence: 1'b0,
                                  wdata: 32'h0, wstrb: 4'h0, due: due});
   endtask

   task automatic req_d(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic fence, input int due);
      dmem_in           = MEM_IN_ZERO;
      dmem_in.mem_valid = 1'b1;
      dmem_in.mem_instr = fence;
      dmem_in.mem_fence = fence;
      dmem_in.mem_addr  = addr;
      dmem_in.mem_wdata = wdata;
      dmem_in.mem_wstrb = wstrb;
      exp_q.push_back('{addr: addr, instr: 1'b0, fence: fence,
                        wdata: wdata, wstrb: wstrb, due: due});
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mcnt != 0 || out_live) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain", 128'(n < budget), 128'h1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst     = 1'b1;
      imem_in = MEM_IN_ZERO;
      dmem_in = MEM_IN_ZERO;
      mem_out = MEM_OUT_ZERO;
      #2;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Idle fetch: granted in the pulse cycle, answered three cycles later.
      mem_lat = 3;
      tick();
      req_i(32'h0000_0100, 1'b1, cyc);
      wait_idle(20);

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
      // Simultaneous pulses: data first, fetch in D's ready cycle.
      mem_lat = 3;
      tick();
      c = cyc;
      req_d(32'h0000_8000, 32'h1234_5678, 4'hF, 1'b0, c);
      req_i(32'h0000_0200, 1'b1, c + 3);
      wait_idle(30);

      // Data flood: four data grants pass the waiting fetch, then it wins.
      mem_lat = 2;
      tick();
      c = cyc;
      req_i(32'h0000_0400, 1'b1, c + 8);
      req_d(32'h0000_9000, 32'hA000_0000, 4'h3, 1'b0, c);
      for (int k = 1; k <= 4; k++) begin
         repeat (2) tick();
         req_d(32'h0000_9000 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF, 1'b0,
               (k < 4) ? c + 2 * k : c + 10);
      end
      wait_idle(40);
`else
      // Both sides always requesting: grants alternate starting with fetch.
      mem_lat = 2;
      tick();
      c = cyc;
      req_i(32'h0000_0500, 1'b1, c);
      req_d(32'h0000_A000, 32'h0000_0001, 4'hF, 1'b0, c + 2);
      for (int k = 1; k <= 4; k++) begin
         repeat (2) tick();
         if (k % 2 == 1) req_i(32'h0000_0500 + 32'(k * 4), 1'b1, c + 2 * (k + 1));
         else req_d(32'h0000_A000 + 32'(k * 4), 32'(k), 4'hF, 1'b0, c + 2 * (k + 1));
      end
      wait_idle(40);
`endif

      // Fence from the data side; instr flag on the input must not leak.
      mem_lat = 2;
      tick();
      req_d(32'h0000_B000, 32'h0, 4'h0, 1'b1, cyc);
      wait_idle(20);

      // Second fetch pulse while the first is still pending is dropped.
      mem_lat = 4;
      tick();
      c = cyc;
      req_d(32'h0000_C000, 32'hCAFE_F00D, 4'hC, 1'b0, c);
      tick();
      req_i(32'h0000_0300, 1'b1, c + 4);
      tick();
      req_i(32'h0000_0340, 1'b0, 0);
      wait_idle(30);

      // Reset in the middle of a data access; the late ready is ignored.
      mem_lat = 4;
      tick();
      req_d(32'h0000_D000, 32'h0BAD_0BAD, 4'hF, 1'b0, cyc);
      tick();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      wait_idle(20);
      tick();

      // Port is usable again after reset, with a one-cycle memory.
      mem_lat = 1;
      tick();
      req_i(32'h0000_0600, 1'b1, cyc);
      wait_idle(20);

      check_eq("queue_empty", 128'(exp_q.size()), 128'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
